video_timing_gen: RTL and testbench



---
 rtl/video_timing_if.sv | 31 +++
 rtl/video_timing_gen.sv | 116 +++++++++++
 tb/tb_video_timing_gen.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_if.sv
// Raster timing bundle: pixel enable into the generator, registered position,
// sync, blanking, strobe and frame-count outputs back out.
interface video_timing_if #(
  parameter int HW      = 9,
  parameter int VW      = 9,
  parameter int FRAME_W = 8
);
  logic               ce;
  logic [HW-1:0]      hpos;
  logic [VW-1:0]      vpos;
  logic               hsync;
  logic               vsync;
  logic               hblank;
  logic               vblank;
  logic               display_on;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_count;

  modport master (
    input  ce,
    output hpos, vpos, hsync, vsync, hblank, vblank, display_on,
           line_start, frame_start, frame_count
  );

  modport slave (
    output ce,
    input  hpos, vpos, hsync, vsync, hblank, vblank, display_on,
           line_start, frame_start, frame_count
  );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator; one clk from a ce step to all outputs.
// No backpressure: ce=0 simply freezes the raster and suppresses the strobes.
module video_timing_gen #(
  parameter int H_DISPLAY = 256,
  parameter int H_FRONT   = 7,
  parameter int H_SYNC    = 23,
  parameter int H_BACK    = 23,
  parameter int V_DISPLAY = 240,
  parameter int V_BOTTOM  = 14,
  parameter int V_SYNC    = 3,
  parameter int V_TOP     = 5,
  parameter int HSYNC_POL = 1,
  parameter int VSYNC_POL = 1,
  parameter int FRAME_W   = 8
) (
  input  logic           clk,
  input  logic           reset,
  video_timing_if.master vt
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_BLANK  = HW'(H_DISPLAY);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_DISPLAY + H_FRONT);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [HW-1:0] H_ONE    = HW'(1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_BLANK  = VW'(V_DISPLAY);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_DISPLAY + V_BOTTOM);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);
  localparam logic [VW-1:0] V_ONE    = VW'(1);
  localparam logic [FRAME_W-1:0] F_ONE = FRAME_W'(1);
  localparam logic HS_ACT = (HSYNC_POL != 0);
  localparam logic VS_ACT = (VSYNC_POL != 0);

  logic [HW-1:0]      hpos_q, hpos_d;
  logic [VW-1:0]      vpos_q, vpos_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               hblank_q, hblank_d;
  logic               vblank_q, vblank_d;
  logic               display_on_q, display_on_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic [FRAME_W-1:0] frame_count_q, frame_count_d;

  always_comb begin
    hpos_d        = hpos_q;
    vpos_d        = vpos_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_count_d = frame_count_q;
    if (vt.ce) begin
      if (hpos_q == H_LAST) begin
        hpos_d       = '0;
        line_start_d = 1'b1;
        if (vpos_q == V_LAST) begin
          vpos_d        = '0;
          frame_start_d = 1'b1;
          frame_count_d = frame_count_q + F_ONE;
        end else begin
          vpos_d = vpos_q + V_ONE;
        end
      end else begin
        hpos_d = hpos_q + H_ONE;
      end
    end
    // Decode from the next position so the registered flags line up with hpos/vpos.
    hsync_d      = ((hpos_d >= HS_FIRST) && (hpos_d <= HS_LAST)) ? HS_ACT : ~HS_ACT;
    vsync_d      = ((vpos_d >= VS_FIRST) && (vpos_d <= VS_LAST)) ? VS_ACT : ~VS_ACT;
    hblank_d     = (hpos_d >= H_BLANK);
    vblank_d     = (vpos_d >= V_BLANK);
    display_on_d = ~hblank_d & ~vblank_d;
  end

  // Reset parks the raster on the last pixel so the first ce lands on (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hpos_q        <= H_LAST;
      vpos_q        <= V_LAST;
      hsync_q       <= ~HS_ACT;
      vsync_q       <= ~VS_ACT;
      hblank_q      <= 1'b1;
      vblank_q      <= 1'b1;
      display_on_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '1;
    end else begin
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      display_on_q  <= display_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign vt.hpos        = hpos_q;
  assign vt.vpos        = vpos_q;
  assign vt.hsync       = hsync_q;
  assign vt.vsync       = vsync_q;
  assign vt.hblank      = hblank_q;
  assign vt.vblank      = vblank_q;
  assign vt.display_on  = display_on_q;
  assign vt.line_start  = line_start_q;
  assign vt.frame_start = frame_start_q;
  assign vt.frame_count = frame_count_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboarded bench: a behavioural raster model pushes expected outputs per step,
// compared after each clock against the default-geometry DUT and two tiny-geometry DUTs.
module tb_video_timing_gen;
  logic clk = 1'b0;
  logic rst;
  logic ce;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  video_timing_if #(.HW(9), .VW(9), .FRAME_W(8)) vif ();
  video_timing_if #(.HW(3), .VW(3), .FRAME_W(8)) sif ();
  video_timing_if #(.HW(3), .VW(3), .FRAME_W(8)) nif ();
  assign vif.ce = ce;
  assign sif.ce = ce;
  assign nif.ce = ce;

  video_timing_gen dut (.clk(clk), .reset(rst), .vt(vif));
  video_timing_gen #(
    .H_DISPLAY(2), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_DISPLAY(2), .V_BOTTOM(1), .V_SYNC(1), .V_TOP(1)
  ) dut_s (.clk(clk), .reset(rst), .vt(sif));
  video_timing_gen #(
    .H_DISPLAY(2), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_DISPLAY(2), .V_BOTTOM(1), .V_SYNC(1), .V_TOP(1),
    .HSYNC_POL(0), .VSYNC_POL(0)
  ) dut_n (.clk(clk), .reset(rst), .vt(nif));

  typedef struct packed {
    logic [31:0] h;
    logic [31:0] v;
    logic        hs, vs, hb, vb, de, ls, fs;
    logic [31:0] fc;
  } obs_t;
  typedef struct {int hd, hf, hsw, hbk, vd, vbt, vsw, vtp, hpol, vpol;} geom_t;
  typedef struct {int h, v, fc; bit ls, fs;} mst_t;

  geom_t gm, gs, gn;
  mst_t  sm, ss, sn;
  obs_t  q_m[$];
  obs_t  q_s[$];
  obs_t  q_n[$];

  function automatic int htot(geom_t g); return g.hd + g.hf + g.hsw + g.hbk; endfunction
  function automatic int vtot(geom_t g); return g.vd + g.vbt + g.vsw + g.vtp; endfunction

  function automatic mst_t m_reset(geom_t g);
    mst_t s;
    s.h = htot(g) - 1; s.v = vtot(g) - 1; s.fc = 255; s.ls = 0; s.fs = 0;
    return s;
  endfunction

  function automatic mst_t m_step(mst_t s, geom_t g, bit c);
    mst_t n = s;
    n.ls = 0; n.fs = 0;
    if (c) begin
      if (s.h == htot(g) - 1) begin
        n.h = 0; n.ls = 1;
        if (s.v == vtot(g) - 1) begin
          n.v = 0; n.fs = 1; n.fc = (s.fc + 1) % 256;
        end else n.v = s.v + 1;
      end else n.h = s.h + 1;
    end
    return n;
  endfunction

  function automatic obs_t m_out(mst_t s, geom_t g);
    obs_t e;
    int hs0 = g.hd + g.hf;
    int vs0 = g.vd + g.vbt;
    e.h  = s.h;
    e.v  = s.v;
    e.hs = (s.h >= hs0 && s.h < hs0 + g.hsw) ? (g.hpol != 0) : (g.hpol == 0);
    e.vs = (s.v >= vs0 && s.v < vs0 + g.vsw) ? (g.vpol != 0) : (g.vpol == 0);
    e.hb = (s.h >= g.hd);
    e.vb = (s.v >= g.vd);
    e.de = !e.hb && !e.vb;
    e.ls = s.ls;
    e.fs = s.fs;
    e.fc = s.fc;
    return e;
  endfunction

  function automatic obs_t obs_m();
    obs_t o;
    o.h = 32'(vif.hpos); o.v = 32'(vif.vpos); o.hs = vif.hsync; o.vs = vif.vsync;
    o.hb = vif.hblank; o.vb = vif.vblank; o.de = vif.display_on;
    o.ls = vif.line_start; o.fs = vif.frame_start; o.fc = 32'(vif.frame_count);
    return o;
  endfunction

  function automatic obs_t obs_s();
    obs_t o;
    o.h = 32'(sif.hpos); o.v = 32'(sif.vpos); o.hs = sif.hsync; o.vs = sif.vsync;
    o.hb = sif.hblank; o.vb = sif.vblank; o.de = sif.display_on;
    o.ls = sif.line_start; o.fs = sif.frame_start; o.fc = 32'(sif.frame_count);
    return o;
  endfunction

  function automatic obs_t obs_n();
    obs_t o;
    o.h = 32'(nif.hpos); o.v = 32'(nif.vpos); o.hs = nif.hsync; o.vs = nif.vsync;
    o.hb = nif.hblank; o.vb = nif.vblank; o.de = nif.display_on;
    o.ls = nif.line_start; o.fs = nif.frame_start; o.fc = 32'(nif.frame_count);
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("h=%0d v=%0d hs=%0b vs=%0b hb=%0b vb=%0b de=%0b ls=%0b fs=%0b fc=%0d",
                     o.h, o.v, o.hs, o.vs, o.hb, o.vb, o.de, o.ls, o.fs, o.fc);
  endfunction

  task automatic drive_main(input bit c);
    @(negedge clk);
    ce = c;
    sm = m_step(sm, gm, c);
    q_m.push_back(m_out(sm, gm));
    @(posedge clk);
    #1;
  endtask

  task automatic drive_small(input bit c);
    @(negedge clk);
    ce = c;
    ss = m_step(ss, gs, c);
    sn = m_step(sn, gn, c);
    q_s.push_back(m_out(ss, gs));
    q_n.push_back(m_out(sn, gn));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e, o;
    rst = 1'b1;
    ce  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sm = m_reset(gm);
    q_m.push_back(m_out(sm, gm));
    e = q_m.pop_front(); o = obs_m(); total++;
    if (o !== e) begin bad++; $display("FAIL reset_state: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_first_pixel();
    obs_t e, o;
    @(negedge clk);
    rst = 1'b0;
    drive_main(1'b1);
    e = q_m.pop_front(); o = obs_m(); total++;
    if (o !== e) begin bad++; $display("FAIL first_pixel: got %s want %s", fmt(o), fmt(e)); end
    total++;
    if (vif.hpos !== 9'd0 || vif.vpos !== 9'd0 || vif.display_on !== 1'b1 ||
        vif.frame_start !== 1'b1 || vif.line_start !== 1'b1 || vif.frame_count !== 8'd0) begin
      bad++; $display("FAIL first_pixel_const: got %s want h=0 v=0 de=1 ls=1 fs=1 fc=0", fmt(o));
    end
    drive_main(1'b1);
    e = q_m.pop_front(); o = obs_m(); total++;
    if (o !== e) begin bad++; $display("FAIL second_pixel: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_line();
    obs_t e, o;
    for (int i = 0; i < 308; i++) begin
      drive_main(1'b1);
      e = q_m.pop_front(); o = obs_m(); total++;
      if (o !== e) begin bad++; $display("FAIL line step %0d: got %s want %s", i, fmt(o), fmt(e)); end
    end
    total++;
    if (vif.hpos !== 9'd0 || vif.vpos !== 9'd1 || vif.line_start !== 1'b1 || vif.frame_start !== 1'b0) begin
      bad++; $display("FAIL line_wrap: got %s want h=0 v=1 ls=1 fs=0", fmt(obs_m()));
    end
  endtask

  task automatic test_full_frame();
    obs_t e, o;
    for (int i = 0; i < 80958 - 309; i++) begin
      drive_main(1'b1);
      e = q_m.pop_front(); o = obs_m(); total++;
      if (o !== e) begin bad++; $display("FAIL frame step %0d: got %s want %s", i, fmt(o), fmt(e)); end
    end
    total++;
    if (vif.hpos !== 9'd0 || vif.vpos !== 9'd0 || vif.frame_start !== 1'b1 ||
        vif.line_start !== 1'b1 || vif.frame_count !== 8'd1) begin
      bad++; $display("FAIL frame_period: got %s want h=0 v=0 ls=1 fs=1 fc=1", fmt(obs_m()));
    end
  endtask

  task automatic test_ce_stall();
    obs_t e, o;
    int pat[4] = '{1, 0, 0, 1};
    for (int i = 0; i < 308; i++) begin
      drive_main(1'b1);
      e = q_m.pop_front(); o = obs_m(); total++;
      if (o !== e) begin bad++; $display("FAIL stall_lead %0d: got %s want %s", i, fmt(o), fmt(e)); end
    end
    for (int k = 0; k < 4; k++) begin
      drive_main(pat[k] != 0);
      e = q_m.pop_front(); o = obs_m(); total++;
      if (o !== e) begin bad++; $display("FAIL stall_step %0d: got %s want %s", k, fmt(o), fmt(e)); end
      total++;
      if (vif.line_start !== (k == 0) || vif.hpos !== ((k == 3) ? 9'd1 : 9'd0) || vif.vpos !== 9'd1) begin
        bad++; $display("FAIL stall_const %0d: got %s want h=%0d v=1 ls=%0b", k, fmt(o), (k == 3), (k == 0));
      end
    end
    for (int i = 0; i < 400; i++) begin
      drive_main($urandom_range(0, 3) != 0);
      e = q_m.pop_front(); o = obs_m(); total++;
      if (o !== e) begin bad++; $display("FAIL random_ce %0d: got %s want %s", i, fmt(o), fmt(e)); end
    end
  endtask

  task automatic test_reset_midframe();
    obs_t e, o;
    for (int i = 0; i < 400 && sm.h != 270; i++) begin
      drive_main(1'b1);
      e = q_m.pop_front(); o = obs_m(); total++;
      if (o !== e) begin bad++; $display("FAIL pre_reset %0d: got %s want %s", i, fmt(o), fmt(e)); end
    end
    total++;
    if (vif.hpos !== 9'd270 || vif.hsync !== 1'b1) begin
      bad++; $display("FAIL pre_reset_hsync: got %s want h=270 hs=1", fmt(obs_m()));
    end
    #2;
    rst = 1'b1;
    ce  = 1'b0;
    #1;
    sm = m_reset(gm);
    q_m.push_back(m_out(sm, gm));
    e = q_m.pop_front(); o = obs_m(); total++;
    if (o !== e) begin bad++; $display("FAIL async_reset: got %s want %s", fmt(o), fmt(e)); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive_main(1'b1);
    e = q_m.pop_front(); o = obs_m(); total++;
    if (o !== e) begin bad++; $display("FAIL after_reset: got %s want %s", fmt(o), fmt(e)); end
    total++;
    if (vif.frame_start !== 1'b1 || vif.frame_count !== 8'd0 || vif.hpos !== 9'd0 || vif.vpos !== 9'd0) begin
      bad++; $display("FAIL after_reset_const: got %s want h=0 v=0 fs=1 fc=0", fmt(o));
    end
  endtask

  task automatic test_small_wrap_polarity();
    obs_t e, o;
    int   n = 0;
    @(negedge clk);
    rst = 1'b1;
    ce  = 1'b0;
    @(posedge clk);
    #1;
    ss = m_reset(gs);
    sn = m_reset(gn);
    q_s.push_back(m_out(ss, gs));
    q_n.push_back(m_out(sn, gn));
    e = q_s.pop_front(); o = obs_s(); total++;
    if (o !== e) begin bad++; $display("FAIL small_reset: got %s want %s", fmt(o), fmt(e)); end
    e = q_n.pop_front(); o = obs_n(); total++;
    if (o !== e) begin bad++; $display("FAIL npol_reset: got %s want %s", fmt(o), fmt(e)); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12000 && n < 256 * 25 + 1; i++) begin
      bit c;
      c = ($urandom_range(0, 7) != 0);
      drive_small(c);
      if (c) n++;
      e = q_s.pop_front(); o = obs_s(); total++;
      if (o !== e) begin bad++; $display("FAIL small step %0d: got %s want %s", i, fmt(o), fmt(e)); end
      e = q_n.pop_front(); o = obs_n(); total++;
      if (o !== e) begin bad++; $display("FAIL npol step %0d: got %s want %s", i, fmt(o), fmt(e)); end
    end
    total++;
    if (sif.frame_count !== 8'd0 || sif.frame_start !== 1'b1 || sif.hpos !== 3'd0 || sif.vpos !== 3'd0) begin
      bad++; $display("FAIL frame_count_wrap: got %s want h=0 v=0 fs=1 fc=0", fmt(obs_s()));
    end
  endtask

  initial begin
    gm = '{hd: 256, hf: 7, hsw: 23, hbk: 23, vd: 240, vbt: 14, vsw: 3, vtp: 5, hpol: 1, vpol: 1};
    gs = '{hd: 2, hf: 1, hsw: 1, hbk: 1, vd: 2, vbt: 1, vsw: 1, vtp: 1, hpol: 1, vpol: 1};
    gn = '{hd: 2, hf: 1, hsw: 1, hbk: 1, vd: 2, vbt: 1, vsw: 1, vtp: 1, hpol: 0, vpol: 0};
    test_reset();
    test_first_pixel();
    test_line();
    test_full_frame();
    test_ce_stall();
    test_reset_midframe();
    test_small_wrap_polarity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: run exceeded its time limit (total=%0d bad=%0d)", total, bad);
    $fatal(1, "timeout");
  end
endmodule
